// File: rtl/skid_register_pkg.sv
// Shared types and constants for the skid register: FSM state encoding
// and the default data width.
package skid_register_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/skid_register_enable_register.sv
// n-bit storage word with load enable and a synchronous active-low clear.
// Clear wins over load.
module enable_register #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         load,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    logic [n-1:0] q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (!clear_n) begin
                    q_reg[gi] <= 1'b0;
                end else if (load) begin
                    q_reg[gi] <= d[gi];
                end
            end
        end
    endgenerate

    assign q = q_reg;

endmodule

// File: rtl/skid_register.sv
// Two-entry skid buffer: registered valid/ready on both sides, strict FIFO
// order, one word per cycle while the downstream keeps out_ready high.
module skid_register
    import skid_register_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t       state_reg;
    state_t       state_next;
    logic         main_load;
    logic         skid_load;
    logic         main_from_skid;
    logic [n-1:0] main_d;
    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready/out_valid are pure state decodes, so the state alone tells us
    // which side may transfer; the raw handshake inputs are used directly here.
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_valid) begin
                    main_load  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    main_load = 1'b1;
                end else if (in_valid) begin
                    skid_load  = 1'b1;
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = BUSY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    enable_register #(.n(n)) u_main (
        .clk     (clk),
        .clear_n (reset_n),
        .load    (main_load),
        .d       (main_d),
        .q       (main_q)
    );

    enable_register #(.n(n)) u_skid (
        .clk     (clk),
        .clear_n (reset_n),
        .load    (skid_load),
        .d       (in_data),
        .q       (skid_q)
    );

    assign out_data  = main_q;
    assign out_valid = (state_reg != EMPTY);
    assign in_ready  = (state_reg != FULL);

endmodule

// File: doc/skid_register.md
SKID_REGISTER -- requirements
Module: skid_register

Interface
REQ-001 SHALL have parameter: n, default 4, data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge only.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_data  input  n  upstream data word.
REQ-005 SHALL have port: in_valid  input  1  upstream word present.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: out_data  output  n  downstream data word.
REQ-008 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-010 SHALL treat an input transfer as in_valid & in_ready at a rising edge, and an output transfer as out_valid & out_ready at a rising edge.
REQ-011 SHALL hold two n-bit storage words: main (drives out_data) and skid (overflow).
REQ-012 SHALL implement 3-state FSM: EMPTY (no word), BUSY (main valid), FULL (main and skid valid).
REQ-013 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from flops only, with no combinational path from in_valid or out_ready.
REQ-014 EMPTY: on in_valid SHALL load main <= in_data and go to BUSY; otherwise stay EMPTY.
REQ-015 BUSY, input and output transfer together: SHALL load main <= in_data and stay BUSY.
REQ-016 BUSY, input transfer only: SHALL load skid <= in_data and go to FULL; main unchanged.
REQ-017 BUSY, output transfer only: SHALL go to EMPTY.
REQ-018 FULL: in_ready = 0, so in_data/in_valid are ignored; on output transfer SHALL load main <= skid and go to BUSY.
REQ-019 Latency: a word accepted at edge k SHALL appear on out_data with out_valid = 1 after edge k; throughput SHALL be one word per cycle while out_ready stays 1.
REQ-020 Ordering SHALL be strict FIFO; no word dropped, duplicated or reordered under any in_valid/out_ready pattern.
REQ-021 out_data SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-022 Unused storage (skid outside FULL, main in EMPTY) SHALL be don't-care but SHALL NOT be visible as valid.

Reset
REQ-023 With reset_n = 0 at a rising edge, SHALL set state = EMPTY, main = 0, skid = 0; hence out_valid = 0, out_data = 0, in_ready = 1 after that edge.
REQ-024 Reset SHALL take priority over any simultaneous transfer; words held at reset are discarded.
REQ-025 Reset SHALL NOT act asynchronously; outputs SHALL change only at clock edges.

Structure
REQ-026 A shared package SHALL hold the state typedef (EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b10) and the default width constant.
REQ-027 Storage SHALL use one sub-module, enable_register (n-bit, load enable, synchronous active-low clear to 0), instantiated twice: main and skid.
REQ-028 Unused state encoding 2'b11 SHALL return to EMPTY on the next edge.

Verification
REQ-029 Reset: hold reset_n = 0 for 2 cycles with in_valid = 1, in_data = 4'hA -> out_valid = 0, out_data = 4'h0, in_ready = 1.
REQ-030 Streaming: out_ready = 1; send 4'h1, 4'h2, 4'h3 on consecutive edges -> out_data 1, 2, 3 on the 3 following cycles, in_ready constant 1.
REQ-031 Backpressure: out_ready = 0; send 4'h5 then 4'h6 -> FULL, in_ready = 0, out_data = 5 held; in_data = 4'h7 presented is not accepted; raise out_ready -> outputs 5 then 6, never 7.
REQ-032 Simultaneous in/out in BUSY: main = 4'h8, in_data = 4'h9, both transfers -> next cycle out_data = 9, state BUSY, in_ready = 1.
REQ-033 Reset mid-operation: in FULL with main = 4'hC, skid = 4'hD, assert reset_n = 0 for one edge -> out_valid = 0, in_ready = 1; later input 4'hE is the first word out.
REQ-034 Random in_valid/out_ready for 10k cycles against a reference queue model -> zero ordering or data mismatches, and depth never exceeds 2.
